// File: rtl/gbe_und_pkg.sv
//-----------------------------------------------------------------------------
// Module      : gbe_und_pkg
// Description : Shared state encoding and status-word layout for the GbE
//               underrun monitor.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package gbe_und_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int STICKY_BIT = 31;
    localparam int STATUS_W   = 32;

    // The upper field sits directly above the underrun count, below the sticky bit.
    function automatic int frm_field_lsb(input int und_w);
        return und_w;
    endfunction

    function automatic int frm_field_msb(input int und_w);
        return STICKY_BIT - 1 + (und_w - und_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gbe_und_satcnt.sv
//-----------------------------------------------------------------------------
// Module      : gbe_und_satcnt
// Description : Up-counter with synchronous clear (clear beats increment) and
//               optional saturation at all-ones.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module gbe_und_satcnt #(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            if (!(SAT_EN && (r_cnt == {WIDTH{1'b1}}))) begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/gbe_und_monitor.sv
//-----------------------------------------------------------------------------
// Module      : gbe_und_monitor
// Description : Counts mid-frame valid gaps (underruns) and completed frames on
//               the loopback mux stream; packs them into a 32-bit status word.
//               Build option GBE_UND_MAXGAP_EN replaces the frame count field
//               with the longest observed gap length.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module gbe_und_monitor
    import gbe_und_pkg::*;
#(
    parameter int UND_W   = 16,
    parameter int FRM_W   = 15,
    parameter int UND_SAT = 1
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        mux_valid,
    input  logic        mux_eof,
    input  logic        sw_clr,
    output logic [31:0] user_data_out,
    output logic        und_pulse
);

    localparam int c_FRM_LSB = frm_field_lsb(UND_W);
    localparam int c_FRM_MSB = frm_field_msb(UND_W);

    generate
        if ((UND_W + FRM_W != 31) || (c_FRM_MSB - c_FRM_LSB + 1 != FRM_W)) begin : g_width_check
            $error("gbe_und_monitor: UND_W + FRM_W must equal 31");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sw_clr_d;
    logic             r_sticky;
    logic             r_und_pulse;
    logic             w_clr;
    logic             w_und_evt;
    logic             w_frm_evt;
    logic [UND_W-1:0] w_und_cnt;
    logic [FRM_W-1:0] w_field;

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_und_evt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (mux_valid && !mux_eof) w_state_nxt = ST_FRAME;
            end
            ST_FRAME: begin
                if (mux_valid && mux_eof) begin
                    w_state_nxt = ST_IDLE;
                end else if (!mux_valid) begin
                    w_state_nxt = ST_GAP;
                    w_und_evt   = 1'b1;
                end
            end
            ST_GAP: begin
                if (mux_valid) w_state_nxt = mux_eof ? ST_IDLE : ST_FRAME;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Eof without valid is meaningless on this bus and never completes a frame.
    assign w_frm_evt = mux_valid && mux_eof;
    assign w_clr     = sw_clr && !r_sw_clr_d;

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_sw_clr_d  <= 1'b0;
            r_sticky    <= 1'b0;
            r_und_pulse <= 1'b0;
        end else begin
            r_sw_clr_d  <= sw_clr;
            r_und_pulse <= w_und_evt;
            if (w_clr) begin
                r_sticky <= 1'b0;
            end else if (w_und_evt) begin
                r_sticky <= 1'b1;
            end
        end
    end

    gbe_und_satcnt #(
        .WIDTH  (UND_W),
        .SAT_EN (UND_SAT != 0)
    ) u_und_cnt (
        .clk   (user_clk),
        .rst   (user_rst),
        .i_inc (w_und_evt),
        .i_clr (w_clr),
        .o_cnt (w_und_cnt)
    );

`ifdef GBE_UND_MAXGAP_EN
    logic [FRM_W-1:0] w_gap_len;
    logic [FRM_W-1:0] r_max_gap;
    logic             w_gap_inc;
    logic             w_gap_exit;

    // The entry cycle counts, so a gap of N idle cycles reads back as N.
    assign w_gap_inc  = w_und_evt || ((r_state == ST_GAP) && !mux_valid);
    assign w_gap_exit = (r_state == ST_GAP) && mux_valid;

    gbe_und_satcnt #(
        .WIDTH  (FRM_W),
        .SAT_EN (1'b1)
    ) u_gap_cnt (
        .clk   (user_clk),
        .rst   (user_rst),
        .i_inc (w_gap_inc),
        .i_clr (w_clr || w_gap_exit),
        .o_cnt (w_gap_len)
    );

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_max_gap <= '0;
        end else if (w_clr) begin
            r_max_gap <= '0;
        end else if (w_gap_exit && (w_gap_len > r_max_gap)) begin
            r_max_gap <= w_gap_len;
        end
    end

    assign w_field = r_max_gap;
`else
    logic [FRM_W-1:0] r_frm_cnt;

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_frm_cnt <= '0;
        end else if (w_clr) begin
            r_frm_cnt <= '0;
        end else if (w_frm_evt) begin
            r_frm_cnt <= r_frm_cnt + {{(FRM_W-1){1'b0}}, 1'b1};
        end
    end

    assign w_field = r_frm_cnt;
`endif

    assign user_data_out = {r_sticky, w_field, w_und_cnt};
    assign und_pulse     = r_und_pulse;

endmodule

`default_nettype wire

// File: tb/tb_gbe_und_monitor.sv
//-----------------------------------------------------------------------------
// Module      : tb_gbe_und_monitor
// Description : Self-checking bench for gbe_und_monitor (default build).
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_gbe_und_monitor;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic        mux_valid;
    logic        mux_eof;
    logic        sw_clr;
    logic [31:0] out_a, out_s, out_w;
    logic        pls_a, pls_s, pls_w;

    int total = 0;
    int bad   = 0;

    always #5 user_clk = ~user_clk;

    gbe_und_monitor #(.UND_W(16), .FRM_W(15), .UND_SAT(1)) dut_a (
        .user_clk(user_clk), .user_rst(user_rst), .mux_valid(mux_valid), .mux_eof(mux_eof),
        .sw_clr(sw_clr), .user_data_out(out_a), .und_pulse(pls_a));

    gbe_und_monitor #(.UND_W(4), .FRM_W(27), .UND_SAT(1)) dut_s (
        .user_clk(user_clk), .user_rst(user_rst), .mux_valid(mux_valid), .mux_eof(mux_eof),
        .sw_clr(sw_clr), .user_data_out(out_s), .und_pulse(pls_s));

    gbe_und_monitor #(.UND_W(4), .FRM_W(27), .UND_SAT(0)) dut_w (
        .user_clk(user_clk), .user_rst(user_rst), .mux_valid(mux_valid), .mux_eof(mux_eof),
        .sw_clr(sw_clr), .user_data_out(out_w), .und_pulse(pls_w));

    // Reference: a frame is "open" after a non-eof valid word; an underrun is
    // the first idle cycle following a valid word of an open frame.
    bit          m_open, m_lastv, m_clr_d, m_sticky, m_pulse;
    logic [15:0] m_und16;
    logic [3:0]  m_und4s, m_und4w;
    logic [14:0] m_frm15;
    logic [26:0] m_frm27;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_open = 0; m_lastv = 0; m_clr_d = 0; m_sticky = 0; m_pulse = 0;
        m_und16 = '0; m_und4s = '0; m_und4w = '0; m_frm15 = '0; m_frm27 = '0;
    endfunction

    function automatic void model_edge(input bit v, input bit e, input bit c);
        bit und, clr;
        und = m_open && !v && m_lastv;
        clr = c && !m_clr_d;
        m_pulse = und;
        if (clr) begin
            m_sticky = 0; m_und16 = '0; m_und4s = '0; m_und4w = '0; m_frm15 = '0; m_frm27 = '0;
        end else begin
            if (und) begin
                m_sticky = 1;
                if (m_und16 != 16'hFFFF) m_und16 = m_und16 + 16'd1;
                if (m_und4s != 4'hF) m_und4s = m_und4s + 4'd1;
                m_und4w = m_und4w + 4'd1;
            end
            if (v && e) begin
                m_frm15 = m_frm15 + 15'd1;
                m_frm27 = m_frm27 + 27'd1;
            end
        end
        if (v) m_open = !e;
        m_lastv = v;
        m_clr_d = c;
    endfunction

    task automatic check_all();
        chk_val("word_a", out_a, {m_sticky, m_frm15, m_und16});
        chk_val("word_sat", out_s, {m_sticky, m_frm27, m_und4s});
        chk_val("word_wrap", out_w, {m_sticky, m_frm27, m_und4w});
        chk_val("pulse_a", {31'd0, pls_a}, {31'd0, m_pulse});
        chk_val("pulse_s", {31'd0, pls_s}, {31'd0, m_pulse});
        chk_val("pulse_w", {31'd0, pls_w}, {31'd0, m_pulse});
    endtask

    task automatic cyc(input bit v, input bit e, input bit c);
        mux_valid = v; mux_eof = e; sw_clr = c;
        @(posedge user_clk);
        model_edge(v, e, c);
        #1;
        check_all();
    endtask

    // Reset pulse between edges; outputs must drop without waiting for a clock.
    task automatic async_rst();
        @(posedge user_clk);
        model_edge(mux_valid, mux_eof, sw_clr);
        #3;
        user_rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        user_rst = 1'b0;
    endtask

    initial begin
        bit c_lvl;
        user_rst = 1'b1; mux_valid = 0; mux_eof = 0; sw_clr = 0;
        model_reset();
        repeat (2) @(posedge user_clk);
        #1;
        check_all();
        chk_val("reset_word", out_a, 32'h0);
        user_rst = 1'b0;

        // Three contiguous 8-word frames.
        for (int f = 0; f < 3; f++)
            for (int w = 0; w < 8; w++) cyc(1, w == 7, 0);
        cyc(0, 0, 0);
        chk_val("three_frames", out_a, 32'h0003_0000);

        // One frame with a 5-cycle hole after word 4.
        async_rst();
        for (int w = 0; w < 4; w++) cyc(1, 0, 0);
        for (int g = 0; g < 5; g++) cyc(0, 1, 0);
        for (int w = 0; w < 4; w++) cyc(1, w == 3, 0);
        chk_val("gap_frame", out_a, 32'h8001_0001);

        // Clear edge coincident with an underrun, then a held level.
        async_rst();
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk_val("clr_vs_und", out_a, 32'h0);
        cyc(0, 0, 1);
        cyc(1, 0, 1);
        cyc(0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(i == 5, i == 5, 1);
        chk_val("clr_level_und", {16'h0, out_a[15:0]}, 32'h1);
        cyc(0, 0, 0);

        // Reset mid-frame, then a clean frame.
        async_rst();
        for (int w = 0; w < 3; w++) cyc(1, 0, 0);
        async_rst();
        chk_val("rst_mid", out_a, 32'h0);
        cyc(0, 0, 0);
        for (int w = 0; w < 4; w++) cyc(1, w == 3, 0);
        cyc(0, 0, 0);
        chk_val("post_rst_frame", out_a, 32'h0001_0000);

        // Random traffic with occasional clears and resets.
        c_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) c_lvl = !c_lvl;
            if ($urandom_range(0, 499) == 0) async_rst();
            else cyc($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 20, c_lvl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
